boot_rom_fetch_port: RTL
========================

// Module: boot_rom_fetch_port
// PURPOSE
//  Instruction-fetch front end for the 1024x32 boot pROM (Gowin_pROM, bypass read, 1-cycle latency).
//  Accepts byte-addressed fetch requests from the CPU over a valid/ready channel and drives the pROM ports.
//  Returns in-order responses through a RSP_DEPTH-entry response FIFO, so CPU back-pressure never stalls a read already in flight.
//  Flags misaligned or out-of-window addresses as errors without touching the ROM. Supports a flush on branch redirect.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte base of the ROM window
//  ADDR_W     10             ROM word-address width (window = 4*2^ADDR_W bytes)
//  DATA_W     32             ROM/response data width
//  RSP_DEPTH  2              response FIFO entries (>=2); also the cap on in-flight plus buffered responses
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       synchronous, active-low reset
//  flush      in   1       discard all in-flight and buffered responses
//  req_valid  in   1       fetch request valid
//  req_ready  out  1       request accepted when req_valid & req_ready
//  req_addr   in   32      byte address
//  rsp_valid  out  1       response valid
//  rsp_ready  in   1       response consumed when rsp_valid & rsp_ready
//  rsp_data   out  DATA_W  instruction word (0 when rsp_err)
//  rsp_err    out  1       misaligned or out-of-window request
//  rom_ce     out  1       to pROM CE
//  rom_oce    out  1       to pROM OCE, tied 1
//  rom_reset  out  1       to pROM RESET, = ~reset_n
//  rom_ad     out  ADDR_W  to pROM AD, = req_addr[ADDR_W+1:2]
//  rom_dout   in   DATA_W  from pROM DO, valid the cycle after rom_ce
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk):
//   - FIFO emptied and pending bit cleared.
//   - rsp_valid=0, rsp_data=0, rsp_err=0.
//   - req_ready=0 and rom_ce=0 while reset_n=0.
//  Definitions:
//   - fire = req_valid & req_ready; pop = rsp_valid & rsp_ready.
//   - ok = (req_addr[1:0]==0) & (BASE_ADDR <= req_addr < BASE_ADDR + 4*2^ADDR_W), 33-bit compare with no wrap.
//  Request side:
//   - req_ready = reset_n & ~flush & (pending + count - pop < RSP_DEPTH).
//   - The combinational path from rsp_ready to req_ready is intentional; it sustains 1 fetch/cycle.
//   - rom_ce = fire & ok, combinational. rom_ad is combinational from req_addr.
//  In-flight stage:
//   - On fire, register pending=1, pend_err=~ok. Otherwise pending=0.
//  Capture:
//   - In the cycle pending=1, push {pend_err ? 0 : rom_dout, pend_err} into the FIFO.
//   - The credit rule guarantees the push never overflows.
//  Response:
//   - rsp_valid = FIFO non-empty; rsp_data/rsp_err come from the registered FIFO head.
//   - Latency: fire in cycle N -> rsp_valid in cycle N+2 (FIFO empty, no flush).
//   - Order is strictly preserved; error responses take a slot like normal ones.
//   - Holding: while rsp_valid & ~rsp_ready, rsp_data/rsp_err stay stable.
//  Simultaneous push and pop: count is unchanged and head advances correctly, including when count==1.
//  Flush (sampled at posedge):
//   - FIFO emptied; pending cleared, so the in-flight rom_dout is dropped.
//   - rsp_valid=0 the next cycle. No fire in the flush cycle.
//   - A request in the cycle after flush proceeds normally.
//  Reset mid-operation discards everything, exactly as flush does.
//  FIFO pointers wrap modulo RSP_DEPTH.
// TESTING
//  - Reset: hold reset_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rom_ce=0, rsp_valid=0 throughout.
//  - Stream: 8 sequential fetches from 0x0 with rsp_ready=1 -> one per cycle; rsp_data 0x000002B7, 0x00C28293, 0x0062A023, 0xFF1FF06F,
//    then 4 zero words; first rsp_valid 2 cycles after first fire.
//  - Back-pressure: rsp_ready=0 with continuous requests -> exactly RSP_DEPTH accepted, then req_ready=0 and data held stable;
//    release -> in-order drain with no loss or duplication.
//  - Errors: addr 0x2 and addr 0x1000 -> rom_ce=0, rsp_err=1, rsp_data=0, in order between valid fetches of 0x0 and 0x4.
//  - Flush: flush asserted while 1 fetch is in flight and 2 responses are buffered -> rsp_valid=0 the next cycle;
//    the next fetch of 0x8 returns 0x0062A023 only.
//  - Random: valid/ready/flush at 30% density for 10k cycles -> scoreboard matches ROM image, in order, with no FIFO overflow.

Source files
------------

// File: rtl/boot_rom_fetch_port.sv
// Instruction-fetch front end for the boot pROM: valid/ready request channel,
// one-cycle ROM read stage and a credit-limited in-order response FIFO.
module boot_rom_fetch_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 32,
    parameter int          RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0]      WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0]      WIN_HI   = WIN_LO + (33'd4 << ADDR_W);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);

    logic              pending_q, pending_d;
    logic              pend_err_q, pend_err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_data_q [RSP_DEPTH];
    logic [DATA_W-1:0] mem_data_d [RSP_DEPTH];
    logic              mem_err_q  [RSP_DEPTH];
    logic              mem_err_d  [RSP_DEPTH];

    logic              addr_ok_s;
    logic              pop_s;
    logic              push_s;
    logic              fire_s;
    logic              req_ready_s;
    logic [CNT_W:0]    occupancy_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake decode; occupancy counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        addr_ok_s   = (req_addr[1:0] == 2'b00)
                    && ({1'b0, req_addr} >= WIN_LO)
                    && ({1'b0, req_addr} <  WIN_HI);
        pop_s       = rsp_valid_q & rsp_ready;
        occupancy_s = (CNT_W + 1)'(pending_q) + {1'b0, count_q} - (CNT_W + 1)'(pop_s);
        req_ready_s = reset_n & ~flush & (occupancy_s < DEPTH_C);
        fire_s      = req_valid & req_ready_s;
        push_s      = pending_q & ~flush;
    end

    // Next-state for the read stage and the response FIFO.
    always_comb begin
        pending_d  = fire_s;
        pend_err_d = ~addr_ok_s;
        mem_data_d = mem_data_q;
        mem_err_d  = mem_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_data_d[wr_ptr_q] = pend_err_q ? {DATA_W{1'b0}} : rom_dout;
                mem_err_d[wr_ptr_q]  = pend_err_q;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        rsp_valid_d = (count_d != {CNT_W{1'b0}});
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            pend_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_W{1'b0}};
                mem_err_q[i]  <= 1'b0;
            end
        end else begin
            pending_q   <= pending_d;
            pend_err_q  <= pend_err_d;
            rsp_valid_q <= rsp_valid_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_data_q  <= mem_data_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = mem_data_q[rd_ptr_q];
    assign rsp_err   = mem_err_q[rd_ptr_q];
    assign rom_ce    = fire_s & addr_ok_s;
    assign rom_oce   = 1'b1;
    assign rom_reset = ~reset_n;
    assign rom_ad    = req_addr[ADDR_W+1:2];

endmodule
